// File: rtl/conv_subblock_reader.sv
// Drains the encoder's three parity subblock FIFOs after computation_done and interleaves them
// into one valid/ready byte stream. Optional CONV_READER_PARITY_EN adds a running triplet XOR.
module conv_subblock_reader #(
  parameter int unsigned LEN_SHORT = 132,
  parameter int unsigned LEN_LONG  = 768,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             computation_done,
  input  logic             code_block_length,
  input  logic             empty,
  input  logic [7:0]       q0,
  input  logic [7:0]       q1,
  input  logic [7:0]       q2,
  output logic             rdreq_subblock,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_stream,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count,
`ifdef CONV_READER_PARITY_EN
  output logic [23:0]      stream_parity,
`endif
  output logic             err_underrun
);

  localparam logic [CNT_W-1:0] LenShort = CNT_W'(LEN_SHORT);
  localparam logic [CNT_W-1:0] LenLong  = CNT_W'(LEN_LONG);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapt,
    StEmit0,
    StEmit1,
    StEmit2,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] length_q, length_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic [7:0]       cap0_q, cap0_d;
  logic [7:0]       cap1_q, cap1_d;
  logic [7:0]       cap2_q, cap2_d;
  logic             last_triplet;

  assign last_triplet = (count_q == length_q);

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    count_d  = count_q;
    err_d    = err_q;
    first_d  = first_q;
    cap0_d   = cap0_q;
    cap1_d   = cap1_q;
    cap2_d   = cap2_q;
    unique case (state_q)
      StIdle: begin
        // Length is only latched here, so a done pulse while busy cannot alter the frame.
        if (computation_done) begin
          state_d  = StRead;
          length_d = code_block_length ? LenLong : LenShort;
          count_d  = '0;
          err_d    = 1'b0;
          first_d  = 1'b1;
        end
      end
      StRead: begin
        if (!empty) begin
          state_d = StCapt;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCapt: begin
        cap0_d  = q0;
        cap1_d  = q1;
        cap2_d  = q2;
        if (!last_triplet) begin
          count_d = count_q + 1'b1;
        end
        state_d = StEmit0;
      end
      StEmit0: begin
        if (out_ready) begin
          first_d = 1'b0;
          state_d = StEmit1;
        end
      end
      StEmit1: begin
        if (out_ready) begin
          state_d = StEmit2;
        end
      end
      StEmit2: begin
        if (out_ready) begin
          state_d = last_triplet ? StDone : StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      length_q <= LenShort;
      count_q  <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      cap0_q   <= '0;
      cap1_q   <= '0;
      cap2_q   <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      count_q  <= count_d;
      err_q    <= err_d;
      first_q  <= first_d;
      cap0_q   <= cap0_d;
      cap1_q   <= cap1_d;
      cap2_q   <= cap2_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them in the same cycle.
  always_comb begin
    rdreq_subblock = 1'b0;
    out_data       = '0;
    out_valid      = 1'b0;
    out_stream     = '0;
    frame_start    = 1'b0;
    frame_end      = 1'b0;
    unique case (state_q)
      StRead: begin
        rdreq_subblock = !empty;
      end
      StEmit0: begin
        out_valid   = 1'b1;
        out_data    = cap0_q;
        out_stream  = 2'd0;
        frame_start = first_q;
      end
      StEmit1: begin
        out_valid  = 1'b1;
        out_data   = cap1_q;
        out_stream = 2'd1;
      end
      StEmit2: begin
        out_valid  = 1'b1;
        out_data   = cap2_q;
        out_stream = 2'd2;
        frame_end  = last_triplet;
      end
      default: begin
      end
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign byte_count   = count_q;
  assign err_underrun = err_q;

`ifdef CONV_READER_PARITY_EN
  logic [23:0] parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (state_q == StIdle && computation_done) begin
      parity_d = '0;
    end else if (state_q == StCapt) begin
      parity_d = parity_q ^ {q2, q1, q0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign stream_parity = parity_q;
`endif

endmodule

// File: doc/conv_subblock_reader.md
Name: conv_subblock_reader

Overview:
- Consumer end of the convolutional encoder's subblock interface.
- After the encoder signals computation done, it drains the three parity subblock FIFOs (q0/q1/q2) through the single shared read request.
- It interleaves the bytes into one byte stream with valid/ready flow control, stream tag and frame markers, for the downstream rate matcher or board display/capture logic.

Parameters:
- LEN_SHORT, 132: bytes per subblock when code_block_length=0.
- LEN_LONG, 768: bytes per subblock when code_block_length=1.
- CNT_W, 11: width of the subblock byte counter; must hold LEN_LONG.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- computation_done  in  1  encoder pulse: all subblock bytes are written.
- code_block_length  in  1  block size select; sampled on the accepted computation_done.
- empty  in  1  encoder subblock FIFO empty.
- q0  in  8  subblock 0 byte; valid the cycle after rdreq_subblock.
- q1  in  8  subblock 1 byte; same timing as q0.
- q2  in  8  subblock 2 byte; same timing as q0.
- rdreq_subblock  out  1  single-cycle read strobe to all three subblock FIFOs.
- out_data  out  8  interleaved output byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte when out_valid and out_ready are both high.
- out_stream  out  2  source of out_data: 0, 1 or 2.
- frame_start  out  1  high with the first byte of a frame.
- frame_end  out  1  high with the last byte of a completed frame.
- busy  out  1  high in every state except IDLE.
- byte_count  out  CNT_W  subblock triplets read so far in the current frame.
- err_underrun  out  1  sticky: FIFO went empty before the length was reached; cleared on next frame start.

Behaviour:
- Reset values (asynchronous, while reset=0): state IDLE; all outputs 0; capture registers 0; length register LEN_SHORT.
- States:
  - IDLE
  - READ: rdreq_subblock=1 only if empty=0.
  - CAPT: latch q0/q1/q2.
  - EMIT0, EMIT1, EMIT2
  - DONE
- IDLE -> READ:
  - on computation_done=1.
  - Latch length = code_block_length ? LEN_LONG : LEN_SHORT.
  - Clear byte_count and err_underrun.
  - Set the first-byte flag.
- READ:
  - empty=0: rdreq_subblock high for exactly one cycle -> CAPT.
  - empty=1: rdreq stays low; set err_underrun -> IDLE.
  - No frame_end is issued on an underrun.
- CAPT:
  - Register q0/q1/q2.
  - byte_count += 1.
  - -> EMIT0.
- EMITn:
  - out_valid=1, out_data=capture[n], out_stream=n.
  - Hold all output values stable until out_ready=1.
  - On handshake: EMIT0->EMIT1, EMIT1->EMIT2.
  - EMIT2 on handshake -> DONE if byte_count==length, else READ.
- frame_start: high with EMIT0 of the first triplet only.
- frame_end: high with EMIT2 of the final triplet only.
- DONE -> IDLE after one cycle.
- Latency and throughput:
  - computation_done to first out_valid: 3 cycles (READ, CAPT, EMIT0).
  - Peak rate: 3 bytes per 5 cycles with out_ready held high.
- computation_done while busy=1 is ignored; it does not restart, and the latched length is unchanged.
- Never assert rdreq_subblock while empty=1, and never more than length times per frame.
- byte_count saturates at length; no wrap.
- Reset mid-frame: immediate return to IDLE, outputs cleared. Any remaining FIFO contents are left for the encoder's own reset.

Optional Feature:
- Macro: CONV_READER_PARITY_EN.
- Defined:
  - Adds output stream_parity [23:0]: running bitwise XOR of all captured q2|q1|q0 triplets in the frame.
  - Cleared on frame start; updated in CAPT; valid from the DONE state until the next frame start.
- Undefined: port absent; no parity logic.

Test Plan:
- Short frame:
  - Stimulus: code_block_length=0; FIFOs preloaded with 132 triplets (q0=i, q1=i+1, q2=i+2); out_ready=1; pulse computation_done.
  - Response: 396 bytes in order 0,1,2,1,2,3,...; exactly 132 rdreq pulses.
  - Response: frame_start on byte 0, frame_end on byte 395; err_underrun=0.
- Backpressure:
  - Stimulus: toggle out_ready randomly at 50%.
  - Response: out_data and out_stream stable while out_valid=1 and out_ready=0; byte sequence identical to the short-frame case.
- Underrun:
  - Stimulus: code_block_length=1 with only 10 triplets loaded.
  - Response: 30 bytes out; err_underrun=1; no frame_end; busy=0; rdreq never high while empty=1.
- Mid-frame reset:
  - Stimulus: assert reset after 50 output bytes.
  - Response: all outputs 0 in the same cycle.
  - Response: a subsequent computation_done starts a clean frame with byte_count=0.
- Overlapping done:
  - Stimulus: a second computation_done pulse mid-frame.
  - Response: ignored; the frame completes normally with the original length.
- Parity (with CONV_READER_PARITY_EN defined):
  - Stimulus: 4 triplets of 0x01/0x02/0x04 at LEN_SHORT=4 (parameter override).
  - Response: stream_parity=0x000000 at DONE.
